// File: rtl/ifetch_pkg.sv
// Shared types for the fetch stage: queue depth default, queue entry layout,
// and the word-alignment helper used for every fetch address.
package ifetch_pkg;

    localparam int IFQ_DEPTH = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_ifq.sv
// Instruction queue: synchronous FIFO of fetch entries with single-cycle flush.
// Push while full is legal only together with a pop (caller guarantees it).
module ifq
    import ifetch_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  fetch_entry_t           din,
    output fetch_entry_t           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t          mem [DEPTH];
    logic         [AW-1:0] wptr, rptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ifetch.sv
// Fetch stage: fetch PC register plus control feeding the instruction queue.
// imem_a comes straight from the fpc register, so ready_i never reaches it.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = IFQ_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcplus8_o
);
    logic [31:0]           fpc;
    logic                  q_full, q_empty, deq, push, pop;
    logic [$clog2(DEPTH):0] q_count;
    fetch_entry_t          q_din, q_head;

    // A dequeue frees a slot on the same edge, so a full queue still fetches.
    assign deq  = valid_o & ready_i;
    assign push = (~q_full | deq) & ~redirect;
    assign pop  = ready_i & ~q_empty & ~redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         fpc <= RESET_PC;
        else if (redirect) fpc <= word_align(redirect_pc);
        else if (push)     fpc <= fpc + 32'd4;
    end

    assign imem_a = word_align(fpc);
    assign q_din  = '{instr: imem_rd, pc: word_align(fpc)};

    ifq #(.DEPTH(DEPTH)) u_ifq (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .din   (q_din),
        .dout  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign valid_o   = (q_count != '0);
    assign instr_o   = q_head.instr;
    assign pc_o      = q_head.pc;
    assign pcplus8_o = q_head.pc + 32'd8;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus randomized
// ready/redirect traffic compared against a queue-based reference model.
module tb_ifetch;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } mentry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1, redirect = 1'b0, ready_i = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_a, imem_rd, instr_o, pc_o, pcplus8_o;
    logic        valid_o;
    logic [31:0] imem_a2, imem_rd2, instr_o2, pc_o2, pcplus8_o2;
    logic        valid_o2;

    logic [31:0] ram [64];
    mentry_t     m_q [$];
    logic [31:0] m_fpc;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign imem_rd  = (imem_a[31:8] == 24'h0) ? ram[imem_a[7:2]] : (imem_a ^ 32'h5A5A_0F0F);
    assign imem_rd2 = (imem_a2[31:8] == 24'h0) ? ram[imem_a2[7:2]] : (imem_a2 ^ 32'h5A5A_0F0F);

    ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect(redirect), .redirect_pc(redirect_pc), .valid_o(valid_o),
        .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o), .pcplus8_o(pcplus8_o)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .reset(reset), .imem_a(imem_a2), .imem_rd(imem_rd2),
        .redirect(1'b0), .redirect_pc(32'h0), .valid_o(valid_o2),
        .ready_i(1'b1), .instr_o(instr_o2), .pc_o(pc_o2), .pcplus8_o(pcplus8_o2)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a[31:8] == 24'h0) return ram[a[7:2]];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // One clock of stimulus; the model applies the fetch rules at the edge.
    task automatic do_cycle(input logic rdr, input logic [31:0] rpc, input logic rdy);
        bit deq, can;
        mentry_t e;
        @(negedge clk);
        redirect = rdr; redirect_pc = rpc; ready_i = rdy;
        @(posedge clk);
        if (rdr) begin
            m_q.delete();
            m_fpc = {rpc[31:2], 2'b00};
        end else begin
            deq = (m_q.size() != 0) && rdy;
            can = (m_q.size() < DEPTH) || deq;
            if (deq) void'(m_q.pop_front());
            if (can) begin
                e.instr = word_at(m_fpc);
                e.pc    = m_fpc;
                m_q.push_back(e);
                m_fpc = m_fpc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; redirect = 1'b0; ready_i = 1'b0; redirect_pc = '0;
        m_q.delete();
        m_fpc = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({valid_o, instr_o, pc_o, pcplus8_o, imem_a} !== {1'b0, 32'h0, 32'h0, 32'h8, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs got v=%b i=%h pc=%h p8=%h a=%h", valid_o, instr_o, pc_o, pcplus8_o, imem_a);
        end
        checks++;
        if (imem_a2 !== 32'hFFFF_FFF8) begin
            errors++; $display("FAIL reset_pc_param got %h exp fffffff8", imem_a2);
        end
        apply_reset();
    endtask

    task automatic test_stream();
        apply_reset();
        do_cycle(1'b0, 32'h0, 1'b1);
        checks++;
        if ({valid_o, instr_o, pc_o, pcplus8_o} !== {1'b1, 32'hE04F_000F, 32'h0, 32'h8}) begin
            errors++;
            $display("FAIL stream_first got v=%b i=%h pc=%h p8=%h", valid_o, instr_o, pc_o, pcplus8_o);
        end
        do_cycle(1'b0, 32'h0, 1'b1);
        checks++;
        if ({valid_o, instr_o, pc_o} !== {1'b1, 32'hE280_2005, 32'h4}) begin
            errors++;
            $display("FAIL stream_second got v=%b i=%h pc=%h exp e2802005 @4", valid_o, instr_o, pc_o);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        repeat (5) do_cycle(1'b0, 32'h0, 1'b0);
        checks++;
        if ({valid_o, instr_o, pc_o, imem_a} !== {1'b1, 32'hE04F_000F, 32'h0, 32'h8}) begin
            errors++;
            $display("FAIL stall_hold got v=%b i=%h pc=%h a=%h", valid_o, instr_o, pc_o, imem_a);
        end
        for (int k = 1; k <= 3; k++) begin
            do_cycle(1'b0, 32'h0, 1'b1);
            checks++;
            if ({valid_o, pc_o, instr_o} !== {1'b1, 32'(4 * k), word_at(32'(4 * k))}) begin
                errors++;
                $display("FAIL stall_drain got v=%b pc=%h i=%h exp pc=%h", valid_o, pc_o, instr_o, 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        repeat (3) do_cycle(1'b0, 32'h0, 1'b0);
        do_cycle(1'b1, 32'h0000_0045, 1'b0);
        checks++;
        if ({valid_o, imem_a} !== {1'b0, 32'h44}) begin
            errors++; $display("FAIL redirect_flush got v=%b a=%h exp v=0 a=44", valid_o, imem_a);
        end
        do_cycle(1'b0, 32'h0, 1'b0);
        checks++;
        if ({valid_o, pc_o, instr_o} !== {1'b1, 32'h44, 32'hE08F_F000}) begin
            errors++;
            $display("FAIL redirect_target got v=%b pc=%h i=%h exp 44/e08ff000", valid_o, pc_o, instr_o);
        end
    endtask

    task automatic test_redirect_deq();
        apply_reset();
        repeat (3) do_cycle(1'b0, 32'h0, 1'b1);
        do_cycle(1'b1, 32'h0000_0020, 1'b1);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL redir_deq_stale got v=%b pc=%h exp v=0", valid_o, pc_o);
        end
        do_cycle(1'b0, 32'h0, 1'b1);
        checks++;
        if ({valid_o, pc_o, instr_o} !== {1'b1, 32'h20, word_at(32'h20)}) begin
            errors++; $display("FAIL redir_deq_target got v=%b pc=%h i=%h exp pc=20", valid_o, pc_o, instr_o);
        end
        do_cycle(1'b0, 32'h0, 1'b1);
        checks++;
        if (pc_o !== 32'h24) begin
            errors++; $display("FAIL redir_deq_next got pc=%h exp 24", pc_o);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            do_cycle(1'b0, 32'h0, 1'b1);
            checks++;
            if ({valid_o2, pc_o2, instr_o2, pcplus8_o2} !== {1'b1, exp_pc[k], word_at(exp_pc[k]), exp_pc[k] + 32'd8}) begin
                errors++;
                $display("FAIL wrap_seq got v=%b pc=%h i=%h p8=%h exp pc=%h", valid_o2, pc_o2, instr_o2, pcplus8_o2, exp_pc[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (2) do_cycle(1'b0, 32'h0, 1'b0);
        checks++;
        if ({valid_o, imem_a} !== {1'b1, 32'h8}) begin
            errors++; $display("FAIL areset_prefill got v=%b a=%h exp v=1 a=8", valid_o, imem_a);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({valid_o, imem_a, instr_o, pc_o} !== {1'b1 ^ 1'b1, 32'h0, 32'h0, 32'h0}) begin
            errors++; $display("FAIL areset_immediate got v=%b a=%h i=%h pc=%h", valid_o, imem_a, instr_o, pc_o);
        end
        m_q.delete();
        m_fpc = 32'h0;
        @(posedge clk);
        #1 reset = 1'b0;
        do_cycle(1'b0, 32'h0, 1'b1);
        checks++;
        if ({valid_o, pc_o, instr_o} !== {1'b1, 32'h0, 32'hE04F_000F}) begin
            errors++; $display("FAIL areset_restart got v=%b pc=%h i=%h", valid_o, pc_o, instr_o);
        end
    endtask

    task automatic test_random();
        logic        rdr, rdy;
        logic [31:0] rpc;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            rdr = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            do_cycle(rdr, rpc, rdy);
            checks++;
            if (valid_o !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rand_valid n=%0d got %b exp %b", n, valid_o, m_q.size() != 0);
            end else if (m_q.size() != 0 &&
                         {instr_o, pc_o, pcplus8_o} !== {m_q[0].instr, m_q[0].pc, m_q[0].pc + 32'd8}) begin
                errors++;
                $display("FAIL rand_head n=%0d got i=%h pc=%h p8=%h exp i=%h pc=%h", n, instr_o, pc_o, pcplus8_o, m_q[0].instr, m_q[0].pc);
            end
            checks++;
            if (imem_a !== m_fpc) begin
                errors++; $display("FAIL rand_fpc n=%0d got %h exp %h", n, imem_a, m_fpc);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        ram[0]  = 32'hE04F_000F;
        ram[1]  = 32'hE280_2005;
        ram[17] = 32'hE08F_F000;
        m_fpc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_deq();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port imem_a  output  32  word-aligned fetch address to instruction memory.
REQ-006 SHALL have port imem_rd  input  32  instruction word; combinational, valid same cycle as imem_a.
REQ-007 SHALL have port redirect  input  1  PC write / taken branch from downstream; flush request.
REQ-008 SHALL have port redirect_pc  input  32  new fetch address when redirect=1.
REQ-009 SHALL have port valid_o  output  1  head queue entry valid toward decode.
REQ-010 SHALL have port ready_i  input  1  decode accepts head entry this cycle.
REQ-011 SHALL have port instr_o  output  32  head instruction word.
REQ-012 SHALL have port pc_o  output  32  address of instr_o.
REQ-013 SHALL have port pcplus8_o  output  32  pc_o + 8 (ARM R15 read value), modulo 2^32.

Function
REQ-014 SHALL hold fetch register fpc; imem_a = {fpc[31:2], 2'b00} at all times.
REQ-015 SHALL enqueue {imem_rd, fpc} and advance fpc by 4 on a clock edge when fetch_en = (count < DEPTH) or dequeue, and redirect=0.
REQ-016 SHALL define dequeue = valid_o & ready_i; head entry removed on that edge.
REQ-017 SHALL keep valid_o, instr_o, pc_o stable while valid_o=1 and ready_i=0.
REQ-018 SHALL drive valid_o = (count != 0); outputs combinational from head entry only.
REQ-019 SHALL allow simultaneous enqueue and dequeue when full; count unchanged, FIFO order kept.
REQ-020 SHALL, on redirect=1, on that edge: clear queue (count=0), discard that cycle's fetch, load fpc = {redirect_pc[31:2], 2'b00}; ignore ready_i that cycle for state change.
REQ-021 SHALL give redirect priority over enqueue, dequeue and full/empty conditions.
REQ-022 SHALL deassert valid_o the cycle after redirect; first target instruction valid the cycle after that (2-cycle redirect-to-valid).
REQ-023 SHALL wrap fpc from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-024 SHALL deliver first instruction with valid_o=1 one cycle after reset deasserts (one fetch edge).
REQ-025 SHALL never drop, duplicate or reorder instructions absent redirect.
REQ-026 SHALL sustain one instruction per cycle when ready_i held 1.

Reset
REQ-027 SHALL, while reset=1, asynchronously set fpc=RESET_PC, count=0, queue pointers=0, entry storage=0.
REQ-028 SHALL, during reset, drive valid_o=0, instr_o=0, pc_o=0, pcplus8_o=8, imem_a=RESET_PC.
REQ-029 SHALL, on reset mid-stream (queue non-empty, redirect pending), discard all state; no partial entry survives.

Structure
REQ-030 SHALL place IFQ_DEPTH default and fetch entry struct {instr[31:0], pc[31:0]} in shared package ifetch_pkg.
REQ-031 SHALL implement queue as one sub-module ifq (synchronous FIFO with flush, count, full/empty); fpc and control in ifetch.
REQ-032 SHALL contain no combinational path from ready_i to imem_a.

Verification
REQ-033 SHALL cover: reset release, imem holding E04F000F,E2802005,... at words 0,1,... , ready_i=1 -> cycle1 valid_o=1 instr_o=E04F000F pc_o=0 pcplus8_o=8; cycle2 E2802005 pc_o=4.
REQ-034 SHALL cover: ready_i=0 for 5 cycles after reset -> fpc stops at 8, queue full, instr_o stays E04F000F; ready_i=1 -> words 0,1,2 delivered in order, no gaps.
REQ-035 SHALL cover: redirect=1 redirect_pc=32'h0000_0045 with queue full -> next cycle valid_o=0; following cycle pc_o=32'h44 instr_o=RAM[17]=E08FF000.
REQ-036 SHALL cover: redirect and dequeue same cycle -> dequeued entry consumed once, no stale entry after flush.
REQ-037 SHALL cover: RESET_PC=32'hFFFF_FFF8, ready_i=1 -> pc_o sequence FFFFFFF8, FFFFFFFC, 00000000; pcplus8_o of FFFFFFFC = 00000004.
REQ-038 SHALL cover: reset asserted asynchronously between edges with count=2 -> valid_o=0 immediately, fpc=RESET_PC.
